// File: rtl/dm_cfg_seq_if.sv
// Configuration handshake between the control/register logic and the
// dual-modulus divider reconfiguration sequencer.
interface dm_cfg_seq_if #(
    parameter int W = 16
) ();
    // A transfer happens on the clk edge where cfg_valid && cfg_ready.
    // cfg_ready is high only while the sequencer is idle; a cfg_valid seen
    // while cfg_ready is low is dropped, never queued, so the master must
    // keep (or re-offer) its settings until it sees them accepted.
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_c;
    logic [W-1:0] cfg_b;
    logic [W-1:0] cfg_n;
    logic [W-1:0] cfg_p;

    modport master (
        output cfg_valid, cfg_c, cfg_b, cfg_n, cfg_p,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_c, cfg_b, cfg_n, cfg_p,
        output cfg_ready
    );
endinterface

// File: rtl/dm_cfg_seq.sv
// Reconfiguration sequencer for the dual-modulus divider: validates a new
// C/B/N/P set, parks the divider in reset on an output edge, loads it, then waits for lock.
module dm_cfg_seq #(
    parameter int W              = 16,
    parameter int HOLD_CYCLES    = 4,
    parameter int SETTLE_EDGES   = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic         clk,
    input  logic         rst,
    dm_cfg_seq_if.slave  cfg,
    output logic         dm_rst_n,
    output logic [W-1:0] dm_c,
    output logic [W-1:0] dm_b,
    output logic [W-1:0] dm_n,
    output logic [W-1:0] dm_p,
    input  logic         dm_signal,
    output logic         busy,
    output logic         locked,
    output logic         cfg_err,
    output logic         timeout,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUIESCE = 2'd1,
        HOLD    = 2'd2,
        SETTLE  = 2'd3
    } state_t;

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int EW = $clog2(SETTLE_EDGES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(SETTLE_EDGES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_t       state_q, state_d;
    logic         dm_rst_n_q, dm_rst_n_d;
    logic [W-1:0] dm_c_q, dm_c_d, dm_b_q, dm_b_d, dm_n_q, dm_n_d, dm_p_q, dm_p_d;
    logic [W-1:0] stg_c_q, stg_c_d, stg_b_q, stg_b_d, stg_n_q, stg_n_d, stg_p_q, stg_p_d;
    logic         busy_q, busy_d;
    logic         locked_q, locked_d;
    logic         cfg_err_q, cfg_err_d;
    logic         timeout_q, timeout_d;
    logic         sig_q, sig_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [EW-1:0] edge_cnt_q, edge_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic          edge_det;
    logic          cfg_legal;
    logic [TW-1:0] tmo_inc;

    assign edge_det  = dm_signal ^ sig_q;
    assign cfg_legal = (cfg.cfg_c != '0) && (cfg.cfg_b <= cfg.cfg_c) &&
                       (cfg.cfg_n != '0) && (cfg.cfg_p != '0);
    // Saturating so a very long wait can never wrap back into range.
    assign tmo_inc   = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + TW'(1);

    always_comb begin
        state_d    = state_q;
        dm_rst_n_d = dm_rst_n_q;
        dm_c_d     = dm_c_q;
        dm_b_d     = dm_b_q;
        dm_n_d     = dm_n_q;
        dm_p_d     = dm_p_q;
        stg_c_d    = stg_c_q;
        stg_b_d    = stg_b_q;
        stg_n_d    = stg_n_q;
        stg_p_d    = stg_p_q;
        busy_d     = busy_q;
        locked_d   = locked_q;
        cfg_err_d  = cfg_err_q;
        timeout_d  = timeout_q;
        sig_d      = dm_signal;
        hold_cnt_d = hold_cnt_q;
        edge_cnt_d = edge_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;

        case (state_q)
            IDLE: begin
                if (cfg.cfg_valid) begin
                    if (cfg_legal) begin
                        cfg_err_d = 1'b0;
                        timeout_d = 1'b0;
                        stg_c_d   = cfg.cfg_c;
                        stg_b_d   = cfg.cfg_b;
                        stg_n_d   = cfg.cfg_n;
                        stg_p_d   = cfg.cfg_p;
                        busy_d    = 1'b1;
                        locked_d  = 1'b0;
                        if (locked_q) begin
                            state_d   = QUIESCE;
                            tmo_cnt_d = '0;
                        end else begin
                            // Staging is written on this same edge, so load the
                            // divider straight from the offered fields.
                            state_d    = HOLD;
                            hold_cnt_d = '0;
                            dm_rst_n_d = 1'b0;
                            dm_c_d     = cfg.cfg_c;
                            dm_b_d     = cfg.cfg_b;
                            dm_n_d     = cfg.cfg_n;
                            dm_p_d     = cfg.cfg_p;
                        end
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            QUIESCE: begin
                if (edge_det || (tmo_cnt_q == TMO_LAST)) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                    dm_rst_n_d = 1'b0;
                    dm_c_d     = stg_c_q;
                    dm_b_d     = stg_b_q;
                    dm_n_d     = stg_n_q;
                    dm_p_d     = stg_p_q;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = SETTLE;
                    dm_rst_n_d = 1'b1;
                    edge_cnt_d = '0;
                    tmo_cnt_d  = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            SETTLE: begin
                // Reaching the edge count wins over a timeout on the same cycle.
                if (edge_det && (edge_cnt_q == EDGE_LAST)) begin
                    locked_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    tmo_cnt_d = tmo_inc;
                    if (edge_det) begin
                        edge_cnt_d = edge_cnt_q + EW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            dm_rst_n_q <= 1'b0;
            dm_c_q     <= W'(1);
            dm_b_q     <= '0;
            dm_n_q     <= W'(1);
            dm_p_q     <= W'(1);
            stg_c_q    <= W'(1);
            stg_b_q    <= '0;
            stg_n_q    <= W'(1);
            stg_p_q    <= W'(1);
            busy_q     <= 1'b0;
            locked_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            sig_q      <= 1'b0;
            hold_cnt_q <= '0;
            edge_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            dm_rst_n_q <= dm_rst_n_d;
            dm_c_q     <= dm_c_d;
            dm_b_q     <= dm_b_d;
            dm_n_q     <= dm_n_d;
            dm_p_q     <= dm_p_d;
            stg_c_q    <= stg_c_d;
            stg_b_q    <= stg_b_d;
            stg_n_q    <= stg_n_d;
            stg_p_q    <= stg_p_d;
            busy_q     <= busy_d;
            locked_q   <= locked_d;
            cfg_err_q  <= cfg_err_d;
            timeout_q  <= timeout_d;
            sig_q      <= sig_d;
            hold_cnt_q <= hold_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    assign cfg.cfg_ready = (state_q == IDLE);
    assign dm_rst_n      = dm_rst_n_q;
    assign dm_c          = dm_c_q;
    assign dm_b          = dm_b_q;
    assign dm_n          = dm_n_q;
    assign dm_p          = dm_p_q;
    assign busy          = busy_q;
    assign locked        = locked_q;
    assign cfg_err       = cfg_err_q;
    assign timeout       = timeout_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_dm_cfg_seq.sv
// Directed bench for dm_cfg_seq driving a behavioural dual-modulus divider,
// with a stuck-output mode to force settle timeouts.
module tb_dm_cfg_seq;
    localparam int W = 16;
    localparam logic [1:0] S_IDLE = 2'd0, S_QUIESCE = 2'd1, S_HOLD = 2'd2, S_SETTLE = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dm_cfg_seq_if #(.W(W)) cfg_if ();

    logic         dm_rst_n;
    logic [W-1:0] dm_c, dm_b, dm_n, dm_p;
    logic         dm_signal, busy, locked, cfg_err, timeout;
    logic [1:0]   dbg_state;

    dm_cfg_seq #(
        .W(W), .HOLD_CYCLES(4), .SETTLE_EDGES(2), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst), .cfg(cfg_if),
        .dm_rst_n(dm_rst_n), .dm_c(dm_c), .dm_b(dm_b), .dm_n(dm_n), .dm_p(dm_p),
        .dm_signal(dm_signal), .busy(busy), .locked(locked), .cfg_err(cfg_err),
        .timeout(timeout), .dbg_state(dbg_state)
    );

    // Divider model: per sequence of C half-periods, the first B last P cycles, the rest N.
    logic         stuck = 1'b0;
    logic         div_out = 1'b0;
    logic [W-1:0] div_cnt = '0;
    logic [W-1:0] div_idx = '0;
    logic [W-1:0] div_len;
    assign div_len   = (div_idx < dm_b) ? dm_p : dm_n;
    assign dm_signal = stuck ? 1'b0 : div_out;

    always @(posedge clk) begin
        if (dm_rst_n !== 1'b1) begin
            div_out <= 1'b0;
            div_cnt <= '0;
            div_idx <= '0;
        end else if (div_cnt == div_len - 16'd1) begin
            div_out <= ~div_out;
            div_cnt <= '0;
            div_idx <= (div_idx == dm_c - 16'd1) ? '0 : div_idx + 16'd1;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // Half-period monitor: run lengths of dm_signal since the last divider release.
    int   obs_q[$];
    int   run_len = 0;
    logic run_prev = 1'b0;
    always @(negedge clk) begin
        if (dm_rst_n !== 1'b1) begin
            obs_q.delete();
            run_len = 0;
            run_prev = 1'b0;
        end else if (dm_signal === run_prev) begin
            run_len++;
        end else begin
            obs_q.push_back(run_len);
            run_len = 1;
            run_prev = dm_signal;
        end
    end

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cfg(input logic [W-1:0] c, input logic [W-1:0] b,
                             input logic [W-1:0] n, input logic [W-1:0] p);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_c = c;
        cfg_if.cfg_b = b;
        cfg_if.cfg_n = n;
        cfg_if.cfg_p = p;
    endtask

    task automatic wait_lock(input string tag, output int cyc);
        cyc = 0;
        while (locked !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, locked, 1'b1);
    endtask

    initial begin
        int cyc, lows, bad, rdy_bad, cnt, n_obs;
        logic sig_prev;
        logic [W-1:0] ill[4][4];
        ill = '{'{16'd4, 16'd1, 16'd0, 16'd3}, '{16'd4, 16'd5, 16'd2, 16'd3},
                '{16'd0, 16'd0, 16'd2, 16'd3}, '{16'd4, 16'd1, 16'd2, 16'd0}};
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_c = '0;
        cfg_if.cfg_b = '0;
        cfg_if.cfg_n = '0;
        cfg_if.cfg_p = '0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_state", dbg_state, S_IDLE);
        check("rst_dm_rst_n", dm_rst_n, 1'b0);
        check("rst_settings", {dm_c, dm_b, dm_n, dm_p}, {16'd1, 16'd0, 16'd1, 16'd1});
        check("rst_flags", {busy, locked, cfg_err, timeout}, 4'b0000);
        check("rst_ready", cfg_if.cfg_ready, 1'b1);
        rst = 1'b1;
        @(negedge clk);

        // First config from reset: straight to HOLD for 4 cycles.
        drive_cfg(16'd4, 16'd1, 16'd2, 16'd3);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        check("t1_state_hold", dbg_state, S_HOLD);
        check("t1_busy_ready", {busy, cfg_if.cfg_ready}, 2'b10);
        lows = 0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (dm_rst_n === 1'b0) lows++;
            if ({dm_c, dm_b, dm_n, dm_p} !== {16'd4, 16'd1, 16'd2, 16'd3}) bad++;
            @(negedge clk);
        end
        check("t1_hold_low_cycles", lows, 4);
        check("t1_hold_settings", bad, 0);
        check("t1_release", {dm_rst_n, dbg_state}, {1'b1, S_SETTLE});
        wait_lock("t1_locked", cyc);
        check("t1_lock_latency", cyc, 6);
        check("t1_idle_after_lock", {busy, cfg_if.cfg_ready, dbg_state}, {2'b01, S_IDLE});
        repeat (14) @(negedge clk);
        exp_q = '{16'd3, 16'd2, 16'd2, 16'd2, 16'd3, 16'd2};
        n_obs = obs_q.size();
        check("t1_half_count", n_obs >= 6, 1'b1);
        for (int i = 0; i < 6 && i < n_obs; i++) begin
            check($sformatf("t1_half_%0d", i), obs_q[i], exp_q.pop_front());
        end

        // Reconfigure while locked: QUIESCE until the next divider edge.
        sig_prev = dm_signal;
        drive_cfg(16'd2, 16'd2, 16'd5, 16'd7);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        check("t2_state_quiesce", dbg_state, S_QUIESCE);
        check("t2_flags", {busy, locked, cfg_if.cfg_ready, dm_rst_n}, 4'b1001);
        check("t2_old_settings", {dm_c, dm_b, dm_n, dm_p}, {16'd4, 16'd1, 16'd2, 16'd3});
        cyc = 0;
        rdy_bad = 0;
        while (dm_signal === sig_prev && cyc < 40) begin
            sig_prev = dm_signal;
            @(negedge clk);
            cyc++;
            if (cfg_if.cfg_ready !== 1'b0) rdy_bad++;
        end
        check("t2_edge_seen", cyc < 40, 1'b1);
        check("t2_state_at_edge", dbg_state, S_QUIESCE);
        @(negedge clk);
        check("t2_hold_after_edge", {dbg_state, dm_rst_n}, {S_HOLD, 1'b0});
        check("t2_new_settings", {dm_c, dm_b, dm_n, dm_p}, {16'd2, 16'd2, 16'd5, 16'd7});
        cyc = 0;
        while (locked !== 1'b1 && cyc < 200) begin
            if (cfg_if.cfg_ready !== 1'b0) rdy_bad++;
            @(negedge clk);
            cyc++;
        end
        check("t2_relocked", locked, 1'b1);
        check("t2_ready_low_while_busy", rdy_bad, 0);
        repeat (16) @(negedge clk);
        n_obs = obs_q.size();
        bad = 0;
        for (int i = 0; i < n_obs; i++) if (obs_q[i] != 7) bad++;
        check("t2_half_count", n_obs >= 2, 1'b1);
        check("t2_half_all_7", bad, 0);

        // Illegal configs are rejected without touching the running divider.
        for (int k = 0; k < 4; k++) begin
            drive_cfg(ill[k][0], ill[k][1], ill[k][2], ill[k][3]);
            @(negedge clk);
            cfg_if.cfg_valid = 1'b0;
            check($sformatf("t3_err_%0d", k), cfg_err, 1'b1);
            check($sformatf("t3_run_%0d", k), {dm_rst_n, locked, busy, dbg_state}, {3'b110, S_IDLE});
            check($sformatf("t3_keep_%0d", k), {dm_c, dm_b, dm_n, dm_p},
                  {16'd2, 16'd2, 16'd5, 16'd7});
        end

        // Legal config clears cfg_err; fields toggled while busy must not leak through.
        drive_cfg(16'd3, 16'd1, 16'd2, 16'd2);
        @(negedge clk);
        check("t6_err_cleared", cfg_err, 1'b0);
        check("t6_accept", {busy, locked, dbg_state}, {2'b10, S_QUIESCE});
        cnt = 0;
        bad = 0;
        while (busy === 1'b1 && cnt < 300) begin
            if (dm_rst_n === 1'b0 && {dm_c, dm_b, dm_n, dm_p} !== {16'd3, 16'd1, 16'd2, 16'd2}) bad++;
            if (cnt % 2 == 0) drive_cfg(16'd5, 16'd2, 16'd4, 16'd4);
            else drive_cfg(16'd6, 16'd3, 16'd3, 16'd3);
            @(negedge clk);
            cnt++;
        end
        check("t6_no_leak", bad, 0);
        check("t6_a_locked", {locked, busy}, 2'b10);
        check("t6_a_settings", {dm_c, dm_b, dm_n, dm_p}, {16'd3, 16'd1, 16'd2, 16'd2});
        drive_cfg(16'd5, 16'd2, 16'd4, 16'd4);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        check("t6_idle_take", {busy, dbg_state}, {1'b1, S_QUIESCE});
        wait_lock("t6_d_locked", cyc);
        check("t6_d_settings", {dm_c, dm_b, dm_n, dm_p}, {16'd5, 16'd2, 16'd4, 16'd4});

        // Stuck divider output: QUIESCE and SETTLE each run out after 64 cycles.
        stuck = 1'b1;
        repeat (3) @(negedge clk);
        drive_cfg(16'd3, 16'd1, 16'd2, 16'd2);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        cnt = 0;
        while (dbg_state === S_QUIESCE && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("t4_quiesce_len", cnt, 64);
        check("t4_no_timeout_flag", timeout, 1'b0);
        cnt = 0;
        while (dbg_state === S_HOLD && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check("t4_hold_len", cnt, 4);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check("t4_settle_len", cnt, 64);
        check("t4_timeout", {timeout, locked, busy, cfg_if.cfg_ready}, 4'b1001);
        check("t4_after", {dm_rst_n, dbg_state}, {1'b1, S_IDLE});
        check("t4_settings_kept", {dm_c, dm_b, dm_n, dm_p}, {16'd3, 16'd1, 16'd2, 16'd2});

        // Asynchronous reset during HOLD cycle 2.
        stuck = 1'b0;
        drive_cfg(16'd4, 16'd1, 16'd2, 16'd3);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
        check("t5_hold1", {dbg_state, timeout}, {S_HOLD, 1'b0});
        @(negedge clk);
        check("t5_hold2", dbg_state, S_HOLD);
        rst = 1'b0;
        #1;
        check("t5_async_state", {dbg_state, cfg_if.cfg_ready, dm_rst_n}, {S_IDLE, 2'b10});
        check("t5_async_settings", {dm_c, dm_b, dm_n, dm_p}, {16'd1, 16'd0, 16'd1, 16'd1});
        check("t5_async_flags", {busy, locked, cfg_err, timeout}, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_post_release", {dbg_state, locked, dm_rst_n}, {S_IDLE, 2'b00});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
